neuron_buffer_scheduler: RTL and testbench
==========================================

Name: neuron_buffer_scheduler

Overview:
- Sequences one layer pass through the neuron-buffer ping-pong pair: streams read addresses to the source buffer and write addresses (PIPE cycles later) to the destination buffer.
- Optionally decimates writes by 2 when pooling is on.
- Toggles the buffer-swap select at layer end.
- Sits between the master controller and the neuron buffer swapper / pooling unit.

Parameters:
depth, 3, log2 of lane count D (passed through for consistency; no logic dependence)
A, 11, neuron buffer address width
PIPE, 4, cycles from a read beat to its result at the destination write port (conv + pool latency), PIPE>=1

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
start  input  1  layer start pulse; sampled only in IDLE
numReads  input  A  read beats for this layer; sampled with start
readBase  input  A  first source address; sampled with start
writeBase  input  A  first destination address; sampled with start
poolCfg  input  1  pooling enable for this layer; sampled with start
stall  input  1  suppresses issue of a read beat this cycle
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse at layer completion
swapSel  output  1  0: N1 is source, N2 is destination; 1: reversed
readAddress  output  A  source buffer address
readValid  output  1  read beat issued this cycle
writeAddress  output  A  destination buffer address
writeEnable  output  1  write beat this cycle
doPooling  output  1  registered poolCfg, held for the whole layer

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0, including swapSel; counters and PIPE-deep valid shift register cleared. A reset mid-layer aborts the layer with no done pulse and no swap.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE:
  - start=1 and numReads!=0 -> READ. Load readAddress=readBase, remaining=numReads, writeAddress=writeBase, doPooling=poolCfg, busy=1.
  - start=1 and numReads==0 -> FIN directly, with no reads and no writes.
- READ:
  - Each cycle with stall=0: readValid=1 and remaining decrements; readAddress increments on the following edge.
  - stall=1: readValid=0 and readAddress is held.
  - Leave for DRAIN on the edge after the beat where remaining reaches 0.
- Valid pipe: readValid enters a PIPE-stage shift register that shifts every cycle, regardless of stall. Stage-PIPE output is the result-valid signal rv.
- Write rule:
  - doPooling=0: writeEnable=rv.
  - doPooling=1: writeEnable=rv on every second rv (2nd, 4th, ...). A parity bit toggles per rv and is cleared at start. With an odd numReads, the final unpaired result is dropped.
  - writeAddress increments on the edge after each writeEnable. Writes per layer = numReads (no pool) or floor(numReads/2) (pool).
- Address arithmetic wraps modulo 2^A; no error flag.
- DRAIN: wait until the shift register is all-zero, then -> FIN. The last rv is seen exactly PIPE cycles after the last readValid.
- FIN (one cycle): done=1, busy=0, swapSel toggles on the exiting edge, -> IDLE.
- Done timing: done is asserted PIPE+1 cycles after the last readValid cycle. For numReads==0, it is asserted the cycle after start.
- start while busy, in DRAIN or in FIN is ignored. A start in the cycle after FIN (IDLE) is accepted normally.
- readValid and writeEnable may be high in the same cycle; the two ports are independent.

Test Plan:
1. Reset release, PIPE=4: all outputs 0, swapSel=0.
2. No pooling, start numReads=5, readBase=0x10, writeBase=0x40:
   - readValid high 5 consecutive cycles, addresses 0x10..0x14.
   - writeEnable 5 beats, addresses 0x40..0x44, first beat 4 cycles after first read.
   - done pulse 5 cycles after last read; swapSel 0->1.
3. Same as 2 with stall high for 2 cycles after the 2nd beat: reads at 0x10,0x11, gap of 2, then 0x12..0x14; writes show the same 2-cycle gap; done is delayed by 2 cycles.
4. poolCfg=1, numReads=7, writeBase=0x00:
   - writes on the 2nd, 4th and 6th results only, addresses 0x00..0x02.
   - 3 writes total; done still 5 cycles after the last read.
5. Back-to-back layers, with start reasserted mid-layer: second start ignored; swapSel toggles once per completed layer (0->1->0 across two layers).
6. Edge cases:
   - numReads=0: done the cycle after start, no reads or writes, swapSel toggles.
   - readBase=0x7FE, numReads=3 (A=11): reads 0x7FE, 0x7FF, 0x000.
   - Assert RST_N low mid-READ: outputs clear immediately and no done pulse.

Source files
------------

// File: rtl/neuron_buffer_scheduler.sv
// Layer-pass sequencer for the neuron-buffer ping-pong pair: streams source read addresses,
// trails them with destination writes PIPE cycles later, and flips the buffer select per layer.
module neuron_buffer_scheduler #(
  parameter int unsigned depth = 3,
  parameter int unsigned A     = 11,
  parameter int unsigned PIPE  = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [A-1:0] numReads,
  input  logic [A-1:0] readBase,
  input  logic [A-1:0] writeBase,
  input  logic         poolCfg,
  input  logic         stall,
  output logic         busy,
  output logic         done,
  output logic         swapSel,
  output logic [A-1:0] readAddress,
  output logic         readValid,
  output logic [A-1:0] writeAddress,
  output logic         writeEnable,
  output logic         doPooling
);

  if (PIPE < 1 || depth > 16) begin : g_param_check
    $error("neuron_buffer_scheduler: PIPE must be >= 1 and depth <= 16");
  end

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e          state_q, state_d;
  logic [A-1:0]    remaining_q, remaining_d;
  logic [A-1:0]    raddr_q, raddr_d;
  logic [A-1:0]    waddr_q, waddr_d;
  logic            pool_q, pool_d;
  logic            parity_q, parity_d;
  logic            swap_q, swap_d;
  logic [PIPE-1:0] vpipe_q, vpipe_d;
  logic [PIPE-1:0] drain_rest;
  logic            read_valid;
  logic            rv;
  logic            write_en;

  assign rv         = vpipe_q[PIPE-1];
  // Contents left once the oldest stage shifts out; zero means the final result is at the output.
  assign drain_rest = vpipe_q << 1;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    pool_d      = pool_q;
    parity_d    = parity_q;
    swap_d      = swap_q;
    read_valid  = 1'b0;

    // In pooling mode only every second result is written; parity marks the pair's second half.
    write_en = rv & (~pool_q | parity_q);
    if (rv) begin
      parity_d = ~parity_q;
    end
    if (write_en) begin
      waddr_d = waddr_q + A'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          raddr_d     = readBase;
          waddr_d     = writeBase;
          remaining_d = numReads;
          pool_d      = poolCfg;
          parity_d    = 1'b0;
          state_d     = (numReads == '0) ? StFin : StRead;
        end
      end
      StRead: begin
        if (!stall) begin
          read_valid  = 1'b1;
          raddr_d     = raddr_q + A'(1);
          remaining_d = remaining_q - A'(1);
          if (remaining_q == A'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (drain_rest == '0) begin
          state_d = StFin;
        end
      end
      StFin: begin
        swap_d  = ~swap_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    vpipe_d = (vpipe_q << 1) | PIPE'(read_valid);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      pool_q      <= 1'b0;
      parity_q    <= 1'b0;
      swap_q      <= 1'b0;
      vpipe_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      pool_q      <= pool_d;
      parity_q    <= parity_d;
      swap_q      <= swap_d;
      vpipe_q     <= vpipe_d;
    end
  end

  assign busy         = (state_q == StRead) || (state_q == StDrain);
  assign done         = (state_q == StFin);
  assign swapSel      = swap_q;
  assign readAddress  = raddr_q;
  assign readValid    = read_valid;
  assign writeAddress = waddr_q;
  assign writeEnable  = write_en;
  assign doPooling    = pool_q;

endmodule

// File: tb/tb_neuron_buffer_scheduler.sv
// Randomized bench for neuron_buffer_scheduler: each layer's read/write/done schedule is
// predicted up front from its parameters and stall pattern, then compared cycle by cycle.
module tb_neuron_buffer_scheduler;
  localparam int A    = 11;
  localparam int PIPE = 4;
  localparam int MAXC = 512;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         start = 1'b0;
  logic [A-1:0] numReads = '0;
  logic [A-1:0] readBase = '0;
  logic [A-1:0] writeBase = '0;
  logic         poolCfg = 1'b0;
  logic         stall = 1'b0;
  logic         busy, done, swapSel, readValid, writeEnable, doPooling;
  logic [A-1:0] readAddress, writeAddress;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_swap = 1'b0;
  bit exp_dp   = 1'b0;

  neuron_buffer_scheduler #(.depth(3), .A(A), .PIPE(PIPE)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .numReads(numReads), .readBase(readBase),
    .writeBase(writeBase), .poolCfg(poolCfg), .stall(stall), .busy(busy), .done(done),
    .swapSel(swapSel), .readAddress(readAddress), .readValid(readValid),
    .writeAddress(writeAddress), .writeEnable(writeEnable), .doPooling(doPooling)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int k);
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      stall = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_eq("idle_rv", readValid, 0);
      check_eq("idle_we", writeEnable, 0);
      check_eq("idle_done", done, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_swap", swapSel, exp_swap);
      @(posedge CLK); #1;
    end
  endtask

  // Cycle 0 is the cycle start is presented; the schedule is derived from the stall pattern.
  task automatic run_layer(input int n, input logic [A-1:0] rb, input logic [A-1:0] wb,
                           input bit pool, input logic [15:0] mask, input int pct,
                           input bit spurious);
    bit           st[MAXC];
    bit           erv[MAXC];
    bit           ewe[MAXC];
    logic [A-1:0] era[MAXC];
    logic [A-1:0] ewa[MAXC];
    int           rc[$];
    int           c, done_c, sp;
    for (int i = 0; i < MAXC; i++) begin
      st[i]  = (i < 16) ? mask[i] : ((i < 300) && ($urandom_range(0, 99) < pct));
      erv[i] = 1'b0;
      ewe[i] = 1'b0;
      era[i] = '0;
      ewa[i] = '0;
    end
    c = 1;
    for (int k = 0; k < n; k++) begin
      while (st[c]) c++;
      rc.push_back(c);
      c++;
    end
    done_c = (n == 0) ? 1 : rc[n-1] + PIPE + 1;
    for (int k = 0; k < n; k++) begin
      erv[rc[k]] = 1'b1;
      era[rc[k]] = rb + A'(k);
      if (!pool || (k % 2 == 1)) begin
        ewe[rc[k] + PIPE] = 1'b1;
        ewa[rc[k] + PIPE] = wb + A'(pool ? k / 2 : k);
      end
    end
    sp = spurious ? $urandom_range(1, done_c) : -1;

    for (int cc = 0; cc <= done_c; cc++) begin
      start = (cc == 0) || (cc == sp);
      if (cc == 0) begin
        numReads  = A'(n);
        readBase  = rb;
        writeBase = wb;
        poolCfg   = pool;
      end else begin
        numReads  = A'($urandom);
        readBase  = A'($urandom);
        writeBase = A'($urandom);
        poolCfg   = 1'($urandom);
      end
      stall = st[cc];
      @(negedge CLK);
      if (cc >= 1) exp_dp = pool;
      check_eq("readValid", readValid, erv[cc]);
      if (erv[cc]) check_eq("readAddress", readAddress, era[cc]);
      check_eq("writeEnable", writeEnable, ewe[cc]);
      if (ewe[cc]) check_eq("writeAddress", writeAddress, ewa[cc]);
      check_eq("done", done, cc == done_c);
      check_eq("busy", busy, (n != 0) && (cc >= 1) && (cc < done_c));
      check_eq("swapSel", swapSel, exp_swap);
      check_eq("doPooling", doPooling, exp_dp);
      @(posedge CLK); #1;
    end
    exp_swap = ~exp_swap;
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_swap", swapSel, 0);
    check_eq("rst_rv", readValid, 0);
    check_eq("rst_we", writeEnable, 0);
    check_eq("rst_raddr", readAddress, 0);
    check_eq("rst_waddr", writeAddress, 0);
    check_eq("rst_dp", doPooling, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    idle_cycles(2);

    // Directed layers
    run_layer(5, 11'h010, 11'h040, 1'b0, 16'h0000, 0, 1'b0);
    run_layer(5, 11'h010, 11'h040, 1'b0, 16'h0018, 0, 1'b0);
    run_layer(7, 11'h123, 11'h000, 1'b1, 16'h0000, 0, 1'b0);
    run_layer(6, 11'h200, 11'h300, 1'b0, 16'h0000, 0, 1'b1);
    run_layer(4, 11'h050, 11'h060, 1'b1, 16'h0000, 0, 1'b1);
    run_layer(0, 11'h055, 11'h066, 1'b0, 16'h0000, 0, 1'b0);
    run_layer(3, 11'h7FE, 11'h7FF, 1'b0, 16'h0000, 0, 1'b0);
    idle_cycles(1);

    // Randomized layers
    for (int i = 0; i < 30; i++) begin
      run_layer($urandom_range(0, 40), A'($urandom), A'($urandom), 1'($urandom),
                16'($urandom), 25, 1'($urandom));
      idle_cycles($urandom_range(0, 2));
    end

    // Reset mid-READ aborts the layer
    start = 1'b1; numReads = 11'd10; readBase = 11'h100; writeBase = 11'h200; poolCfg = 1'b1;
    stall = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    check_eq("pre_rst_busy", busy, 1);
    RST_N = 1'b0;
    #1;
    check_eq("arst_rv", readValid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_swap", swapSel, 0);
    check_eq("arst_raddr", readAddress, 0);
    check_eq("arst_dp", doPooling, 0);
    exp_swap = 1'b0;
    exp_dp = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    idle_cycles(15);
    run_layer(2, 11'h001, 11'h002, 1'b0, 16'h0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
